// File: rtl/instr_assembler_pkg.sv
// instr_assembler_pkg: shared encodings for the instruction assembler and its benches
package instr_assembler_pkg;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_R = 2'b11;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ENC  = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  typedef struct packed {
    logic [1:0]  src;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } fields_t;
endpackage

// File: rtl/instr_assembler_pack.sv
// instr_pack: combinational RV32I field packer with immediate range check
module instr_pack
  import instr_assembler_pkg::*;
(
  input  logic [1:0]  src,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal
);
  logic fit12, fit13;
  // Pack by format; I/S must fit 12 signed bits, B 13 signed bits and be even
  always_comb begin
    fit12 = &imm[31:11] | ~|imm[31:11];
    fit13 = &imm[31:12] | ~|imm[31:12];
    word  = src == IMM_I ? {imm[11:0], rs1, funct3, rd, opcode} :
            src == IMM_S ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} :
            src == IMM_B ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode} :
                           {funct7, rs2, rs1, funct3, rd, opcode};
    legal = src == IMM_R ? 1'b1 : src == IMM_B ? fit13 & ~imm[0] : fit12;
  end
endmodule

// File: rtl/instr_assembler.sv
// instr_assembler: packs decoded fields into RV32I words and writes them sequentially to memory
module instr_assembler
  import instr_assembler_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               ImmSrc,
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  input  logic [4:0]               rd,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  input  logic [31:0]              imm,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_ready,
  output logic                     err_pulse,
  output logic                     err_sticky,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  logic [1:0]  state;
  fields_t     f;
  logic [31:0] word;
  logic        legal;
  instr_pack u_pack (
    .src(f.src), .opcode(f.opcode), .funct3(f.funct3), .funct7(f.funct7),
    .rd(f.rd), .rs1(f.rs1), .rs2(f.rs2), .imm(f.imm),
    .word(word), .legal(legal)
  );
  // Handshake and reject pulse; held low while reset is asserted or clear wins
  always_comb begin
    in_ready  = rst & (state == ST_IDLE) & ~full;
    err_pulse = (state == ST_ENC) & ~legal & ~clear;
  end
  // Capture the field bundle on acceptance
  always_ff @(posedge clk or negedge rst)
    if (!rst) f <= '0;
    else if (!clear && in_valid && in_ready)
      f <= '{ImmSrc, opcode, funct3, funct7, rd, rs1, rs2, imm};
  // Sequencer: accept, encode, write; owns pointer, count and flags
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= ST_IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= '0;
      err_sticky <= 1'b0;
      full       <= 1'b0;
      count      <= '0;
    end else if (clear) begin
      state      <= ST_IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      err_sticky <= 1'b0;
      full       <= 1'b0;
      count      <= '0;
    end else if (state == ST_IDLE) begin
      if (in_valid && in_ready) state <= ST_ENC;
    end else if (state == ST_ENC) begin
      state      <= legal ? ST_WR : ST_IDLE;
      mem_we     <= legal;
      mem_wdata  <= legal ? word : mem_wdata;
      err_sticky <= err_sticky | ~legal;
    end else if (mem_ready) begin
      state    <= ST_IDLE;
      mem_we   <= 1'b0;
      count    <= count + 1'b1;
      full     <= count == LAST;
      mem_addr <= count == LAST ? mem_addr : mem_addr + 32'd4;
    end
endmodule

// File: tb/tb_instr_assembler.sv
// tb_instr_assembler: directed checks of packing, handshake, errors, full, clear and reset
module tb_instr_assembler;
  import instr_assembler_pkg::*;
  logic        clk = 0, rst = 0, clear = 0, in_valid = 0, mem_ready = 1;
  logic [1:0]  imm_src = 0;
  logic [6:0]  opcode = 0, funct7 = 0;
  logic [2:0]  funct3 = 0;
  logic [4:0]  rd = 0, rs1 = 0, rs2 = 0;
  logic [31:0] imm = 0;
  logic        in_ready, mem_we, err_pulse, err_sticky, full;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  count;
  int total = 0, bad = 0;
  instr_assembler #(.BASE_ADDR(32'h0), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .ImmSrc(imm_src), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .full(full), .count(count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // present one bundle in a cycle where it must be accepted; returns in ENC
  task automatic offer(input logic [1:0] s, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] d, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [31:0] im);
    imm_src = s; opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = r1; rs2 = r2; imm = im;
    check("offer_rdy", in_ready, 1);
    in_valid = 1;
    tick;
    in_valid = 0;
  endtask
  // full write with mem_ready high: ENC, WR, back in IDLE after exactly three edges
  task automatic write_word(input string tag, input logic [31:0] w, input logic [31:0] a,
                            input logic [2:0] c);
    check({tag, "_enc_rdy"}, in_ready, 0);
    check({tag, "_enc_we"}, mem_we, 0);
    tick;
    check({tag, "_we"}, mem_we, 1);
    check({tag, "_wdata"}, mem_wdata, w);
    check({tag, "_addr"}, mem_addr, a);
    check({tag, "_wr_rdy"}, in_ready, 0);
    tick;
    check({tag, "_we_off"}, mem_we, 0);
    check({tag, "_count"}, count, c);
  endtask
  initial begin
    #1;
    check("rst_rdy", in_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_cnt", count, 0);
    check("rst_flags", {err_pulse, err_sticky, full}, 0);
    tick;
    rst = 1;
    tick;
    check("idle_rdy", in_ready, 1);
    offer(IMM_I, OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    write_word("addi", 32'h0050_0093, 32'h0, 3'd1);
    check("addi_next", mem_addr, 32'h4);
    offer(IMM_S, OP_STORE, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    write_word("sw", 32'h0020_A423, 32'h4, 3'd2);
    offer(IMM_B, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4);
    write_word("beq", 32'hFE20_8EE3, 32'h8, 3'd3);
    offer(IMM_I, OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    check("ei_pulse", err_pulse, 1);
    tick;
    check("ei_pulse_off", err_pulse, 0);
    check("ei_sticky", err_sticky, 1);
    check("ei_we", mem_we, 0);
    check("ei_cnt", count, 3);
    check("ei_rdy", in_ready, 1);
    offer(IMM_B, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    check("eb_pulse", err_pulse, 1);
    tick;
    check("eb_pulse_off", err_pulse, 0);
    check("eb_we", mem_we, 0);
    check("eb_cnt", count, 3);
    check("eb_addr", mem_addr, 32'hC);
    mem_ready = 0;
    offer(IMM_R, OP_REG, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'hDEAD_BEEF);
    tick;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {31'd0, mem_we} ^ (mem_wdata ^ 32'h0020_81B3), 1);
      check("bp_addr", mem_addr, 32'hC);
      check("bp_cnt", count, 3);
      tick;
    end
    mem_ready = 1;
    check("bp_we_last", mem_we, 1);
    tick;
    check("full_we", mem_we, 0);
    check("full_cnt", count, 4);
    check("full_flag", full, 1);
    check("full_rdy", in_ready, 0);
    check("full_addr", mem_addr, 32'hC);
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("full_ignore", {in_ready, mem_we, err_pulse, count}, {3'b000, 3'd4});
    end
    in_valid = 0;
    clear = 1;
    tick;
    clear = 0;
    check("clr_addr", mem_addr, 0);
    check("clr_cnt", count, 0);
    check("clr_flags", {err_sticky, full}, 0);
    check("clr_rdy", in_ready, 1);
    mem_ready = 0;
    offer(IMM_I, OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    tick;
    check("cw_we", mem_we, 1);
    clear = 1;
    mem_ready = 1;
    tick;
    clear = 0;
    check("cw_we_off", mem_we, 0);
    check("cw_cnt", count, 0);
    check("cw_addr", mem_addr, 0);
    mem_ready = 0;
    offer(IMM_I, OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7);
    tick;
    check("rw_we", mem_we, 1);
    rst = 0;
    #1;
    check("rw_we_async", mem_we, 0);
    check("rw_rdy", in_ready, 0);
    tick;
    rst = 1;
    mem_ready = 1;
    tick;
    check("rw_addr", mem_addr, 0);
    check("rw_wdata", mem_wdata, 0);
    check("rw_cnt", count, 0);
    check("rw_flags", {mem_we, err_sticky, full}, 0);
    check("rw_rdy_back", in_ready, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
